ultrasonic_echo_emulator: RTL
=============================

# ultrasonic_echo_emulator

Synthesizable model of the sensor side of the ultrasonic ranging interface. It accepts the trigger pulse from the ranging controller and answers with an echo pulse whose width encodes a programmed distance. It supports hardware-in-loop and FPGA bring-up of the ranging/display path without a physical transducer: the controller's `trigger` output drives this block's `trigger` input, and this block's `echo` output drives the controller's `echo` input.

## Interface
- `TRIG_MIN_CYC`, default 500: minimum accepted trigger high width, in cycles (10 us at 50 MHz).
- `BURST_DELAY_CYC`, default 10000: delay from accepted trigger fall to echo rise (emulated 8-cycle 40 kHz burst).
- `CYC_PER_CM`, default 2924: echo cycles per centimetre. Matches the controller's scaling of distance = cycles*171/500000.
- `MAX_CM`, default 400: largest in-range distance.
- `TIMEOUT_CYC`, default 1900000: echo width when the distance is out of range (38 ms).
- `HOLDOFF_CYC`, default 3000000: dead time after echo fall before the next trigger is accepted.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `trigger`  in  1  trigger from the controller. Treated as asynchronous; passes through an internal 2-flop synchronizer.
- `dist_cm`  in  9  programmed distance in cm. Sampled once per measurement.
- `echo`  out  1  echo pulse (registered).
- `busy`  out  1  high in every state except IDLE and TRIG_HIGH.
- `trig_err`  out  1  one-cycle pulse when a trigger is rejected as too short.
- `last_cm`  out  9  value of `dist_cm` latched for the current or most recent measurement.
- `meas_cnt`  out  16  number of accepted triggers; wraps from 0xFFFF to 0.

## Operation
- FSM states: IDLE, TRIG_HIGH, BURST, ECHO, HOLDOFF.
- Synchronized trigger `trig_s` is the output of the second synchronizer flop. A rising edge is defined as `trig_s`=1 with its previous value 0.
- IDLE:
  - On a rising edge of `trig_s`, go to TRIG_HIGH with the high counter set to 1.
  - A trigger that is already high on entry to IDLE is not accepted. A new rising edge is required.
- TRIG_HIGH:
  - Count cycles while `trig_s`=1. The counter saturates at `TRIG_MIN_CYC`.
  - When `trig_s`=0 and count ≥ `TRIG_MIN_CYC`: latch `dist_cm` into `last_cm`, compute `echo_len`, increment `meas_cnt`, go to BURST.
  - When `trig_s`=0 and count < `TRIG_MIN_CYC`: pulse `trig_err` for one cycle, go to IDLE.
  - A trigger stuck high holds the FSM in TRIG_HIGH indefinitely.
- `echo_len` rules:
  - If `dist_cm` is 0 or greater than `MAX_CM`, `echo_len` = `TIMEOUT_CYC`.
  - Otherwise `echo_len` = `dist_cm`*`CYC_PER_CM`. This is an unsigned product, at least 21 bits, and is never truncated.
  - The `echo_len` counter is wide enough for max(`MAX_CM`*`CYC_PER_CM`, `TIMEOUT_CYC`).
- BURST: wait `BURST_DELAY_CYC` cycles, then go to ECHO.
- ECHO: `echo`=1 for exactly `echo_len` cycles, then go to HOLDOFF.
- HOLDOFF: `echo`=0 for `HOLDOFF_CYC` cycles, then go to IDLE.
- Triggers in BURST, ECHO or HOLDOFF are ignored: no `trig_err` and no count.
- Changes to `dist_cm` after the latch do not affect the measurement in flight.

## Timing
- Reset values: `echo`=0, `busy`=0, `trig_err`=0, `last_cm`=0, `meas_cnt`=0, synchronizer flops=0, state=IDLE.
- Asserting reset mid-measurement forces `echo` low immediately (asynchronous), with no completion.
- Let raw `trigger` fall be sampled at clock edge E:
  - `trig_s` is 0 after E+1.
  - The FSM leaves TRIG_HIGH at E+2. `busy` and `meas_cnt` update at E+2; `trig_err` is high for the cycle following E+2.
- `echo` rises at edge E+2+`BURST_DELAY_CYC` and falls at that edge + `echo_len`.
- The earliest acceptable next rising edge of `trig_s` is sampled at echo-fall edge + `HOLDOFF_CYC` + 1.
- The measured high width is the `trig_s` width, which equals the raw width. Raw pulses shorter than 2 cycles may be lost by the synchronizer; that is acceptable.

## Test plan
Bench parameters: `TRIG_MIN_CYC`=10, `BURST_DELAY_CYC`=20, `CYC_PER_CM`=3, `MAX_CM`=400, `TIMEOUT_CYC`=1500, `HOLDOFF_CYC`=50.
- Nominal measurement: `dist_cm`=100, 12-cycle trigger.
  - `echo` rises 22 cycles after the raw fall edge and is high for exactly 300 cycles.
  - `meas_cnt`=1, `last_cm`=100.
- Short trigger: 9-cycle trigger.
  - One-cycle `trig_err`, no `echo`, `meas_cnt` unchanged, `busy` stays 0.
- Out of range:
  - `dist_cm`=0 gives a 1500-cycle echo.
  - `dist_cm`=401 gives a 1500-cycle echo.
  - `dist_cm`=400 gives a 1200-cycle echo.
- Re-trigger during ECHO and during HOLDOFF: those triggers are ignored.
  - A trigger rising 51 cycles after echo fall is accepted; `meas_cnt` increments once per accepted trigger.
- Drive `rst_n` low 100 cycles into ECHO.
  - `echo` drops immediately and all outputs take their reset values.
  - After release, a trigger held high across the reset release is not accepted until it goes low and rises again.
- Preset `meas_cnt` to 0xFFFF by running 65535 short-parameter measurements, then issue one accepted trigger: `meas_cnt` wraps to 0.
- Change `dist_cm` from 100 to 50 during BURST: the echo is still 300 cycles.

Source files
------------

// File: rtl/ultrasonic_echo_emulator_if.sv
// Sensor-side bus of the ultrasonic echo emulator: trigger/distance in, echo and status out.
interface ultrasonic_echo_emulator_if;
    localparam int unsigned DIST_W = 9;
    localparam int unsigned MCNT_W = 16;

    logic              trigger;
    logic [DIST_W-1:0] dist_cm;
    logic              echo;
    logic              busy;
    logic              trig_err;
    logic [DIST_W-1:0] last_cm;
    logic [MCNT_W-1:0] meas_cnt;

    // Controller / bench side
    modport master (
        output trigger, dist_cm,
        input  echo, busy, trig_err, last_cm, meas_cnt
    );

    // Emulator side
    modport slave (
        input  trigger, dist_cm,
        output echo, busy, trig_err, last_cm, meas_cnt
    );
endinterface

// File: rtl/ultrasonic_echo_emulator.sv
// Emulates an ultrasonic ranging sensor: validates the trigger pulse, waits out the
// emulated burst, then returns an echo whose width encodes the programmed distance.
module ultrasonic_echo_emulator #(
    parameter int unsigned TRIG_MIN_CYC    = 500,
    parameter int unsigned BURST_DELAY_CYC = 10000,
    parameter int unsigned CYC_PER_CM      = 2924,
    parameter int unsigned MAX_CM          = 400,
    parameter int unsigned TIMEOUT_CYC     = 1900000,
    parameter int unsigned HOLDOFF_CYC     = 3000000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    ultrasonic_echo_emulator_if.slave   bus_if
);
    localparam int unsigned DIST_W    = 9;
    localparam int unsigned MCNT_W    = 16;
    localparam int unsigned PROD_MAX  = MAX_CM * CYC_PER_CM;
    localparam int unsigned LEN_MAX   = (PROD_MAX > TIMEOUT_CYC) ? PROD_MAX : TIMEOUT_CYC;
    localparam int unsigned DLY_MAX0  = (BURST_DELAY_CYC > HOLDOFF_CYC) ? BURST_DELAY_CYC : HOLDOFF_CYC;
    localparam int unsigned DLY_MAX   = (DLY_MAX0 > TRIG_MIN_CYC) ? DLY_MAX0 : TRIG_MIN_CYC;
    localparam int unsigned ALL_MAX   = (LEN_MAX > DLY_MAX) ? LEN_MAX : DLY_MAX;
    localparam int unsigned CNT_W_RAW = $clog2(ALL_MAX + 1);
    localparam int unsigned CNT_W     = (CNT_W_RAW < 21) ? 21 : CNT_W_RAW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG_HIGH,
        S_BURST,
        S_ECHO,
        S_HOLDOFF
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    echo_len_q, echo_len_d;
    logic [DIST_W-1:0]   last_cm_q, last_cm_d;
    logic [MCNT_W-1:0]   meas_cnt_q, meas_cnt_d;
    logic                echo_q, echo_d;
    logic                busy_q, busy_d;
    logic                trig_err_q, trig_err_d;

    logic                trig_m_q, trig_s_q, trig_prev_q;
    logic [1:0]          sync_vld_q;
    logic                armed_q;
    logic                rise_c;
    logic                in_range_c;
    logic [CNT_W-1:0]    len_c;

    // Two-flop synchronizer plus edge history. armed_q stays low until a genuine low
    // trig_s has been seen after reset, so a trigger held across reset release is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_m_q    <= 1'b0;
            trig_s_q    <= 1'b0;
            trig_prev_q <= 1'b0;
            sync_vld_q  <= 2'b00;
            armed_q     <= 1'b0;
        end else begin
            trig_m_q    <= bus_if.trigger;
            trig_s_q    <= trig_m_q;
            trig_prev_q <= trig_s_q;
            sync_vld_q  <= {sync_vld_q[0], 1'b1};
            armed_q     <= armed_q | (sync_vld_q[1] & ~trig_s_q);
        end
    end

    assign rise_c = trig_s_q & ~trig_prev_q & armed_q;

    // Echo length for the current dist_cm; only in-range products are used, so no truncation.
    always_comb begin
        in_range_c = (bus_if.dist_cm != '0) && (32'(bus_if.dist_cm) <= MAX_CM);
        len_c      = in_range_c ? (CNT_W'(bus_if.dist_cm) * CNT_W'(CYC_PER_CM))
                                : CNT_W'(TIMEOUT_CYC);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        echo_len_d = echo_len_q;
        last_cm_d  = last_cm_q;
        meas_cnt_d = meas_cnt_q;
        trig_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rise_c) begin
                    state_d = S_TRIG_HIGH;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_TRIG_HIGH: begin
                if (trig_s_q) begin
                    if (cnt_q < CNT_W'(TRIG_MIN_CYC)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (cnt_q >= CNT_W'(TRIG_MIN_CYC)) begin
                    state_d    = S_BURST;
                    cnt_d      = '0;
                    last_cm_d  = bus_if.dist_cm;
                    echo_len_d = len_c;
                    meas_cnt_d = meas_cnt_q + MCNT_W'(1);
                end else begin
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                    trig_err_d = 1'b1;
                end
            end
            S_BURST: begin
                if (cnt_q == CNT_W'(BURST_DELAY_CYC - 1)) begin
                    state_d = S_ECHO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ECHO: begin
                if (cnt_q == echo_len_q - CNT_W'(1)) begin
                    state_d = S_HOLDOFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLDOFF: begin
                if (cnt_q == CNT_W'(HOLDOFF_CYC - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        echo_d = (state_d == S_ECHO);
        busy_d = (state_d != S_IDLE) && (state_d != S_TRIG_HIGH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            echo_len_q <= '0;
            last_cm_q  <= '0;
            meas_cnt_q <= '0;
            echo_q     <= 1'b0;
            busy_q     <= 1'b0;
            trig_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            echo_len_q <= echo_len_d;
            last_cm_q  <= last_cm_d;
            meas_cnt_q <= meas_cnt_d;
            echo_q     <= echo_d;
            busy_q     <= busy_d;
            trig_err_q <= trig_err_d;
        end
    end

    assign bus_if.echo     = echo_q;
    assign bus_if.busy     = busy_q;
    assign bus_if.trig_err = trig_err_q;
    assign bus_if.last_cm  = last_cm_q;
    assign bus_if.meas_cnt = meas_cnt_q;

endmodule
